// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter sequencer: state encodings and mode values.
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        TERM = 2'd3
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/counter_seq_ctrl.sv
// Sequencer for the reloadable up counter: loads a start value, enables counting
// until the end value is seen, pulses DONE and optionally reloads (periodic mode).
module counter_seq_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int EVT_W = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             STOP,
    input  logic             MODE,
    input  logic [WIDTH-1:0] START_VAL,
    input  logic [WIDTH-1:0] END_VAL,
    input  logic [WIDTH-1:0] COUNT,
    output logic             CNT_LOAD,
    output logic             CNT_ENA,
    output logic [WIDTH-1:0] CNT_DATA,
    output logic             BUSY,
    output logic             DONE,
    output logic [EVT_W-1:0] EVENTS
);

    state_t           state;
    state_t           state_nxt;
    logic             mode_lat;
    logic [WIDTH-1:0] start_lat;
    logic [WIDTH-1:0] end_lat;
    logic [EVT_W-1:0] events_q;
    logic             accept;
    logic             at_end;
    logic             evt_sat;

    assign accept  = (state == IDLE) && START && !STOP;
    assign at_end  = (COUNT == end_lat);
    assign evt_sat = (events_q == {EVT_W{1'b1}});

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // STOP overrides every non-IDLE transition, including the TERM reload.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (START && !STOP) state_nxt = LOAD;
            LOAD: state_nxt = RUN;
            RUN:  if (at_end) state_nxt = TERM;
            TERM: state_nxt = (mode_lat == MODE_PERIODIC) ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (STOP && state != IDLE) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            mode_lat  <= MODE_ONESHOT;
            start_lat <= '0;
            end_lat   <= '0;
        end else if (accept) begin
            mode_lat  <= MODE;
            start_lat <= START_VAL;
            end_lat   <= END_VAL;
        end
    end

    // A completed window counts even if STOP arrives in the same cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            events_q <= '0;
        end else if (accept) begin
            events_q <= '0;
        end else if (state == TERM && !evt_sat) begin
            events_q <= events_q + 1'b1;
        end
    end

    always_comb begin
        CNT_LOAD = 1'b0;
        CNT_ENA  = 1'b0;
        BUSY     = 1'b0;
        DONE     = 1'b0;
        unique case (state)
            IDLE: begin
            end
            LOAD: begin
                CNT_LOAD = 1'b1;
                BUSY     = 1'b1;
            end
            RUN: begin
                CNT_ENA = !at_end;
                BUSY    = 1'b1;
            end
            TERM: begin
                DONE = 1'b1;
                BUSY = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign CNT_DATA = start_lat;
    assign EVENTS   = events_q;

endmodule
